// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses pll_reset, waits for a stable lock, then releases sys_resetn.
// Optional build macro PLL_LOCK_DEGLITCH_EN filters 1-2 cycle lock drops while in RUN.
//
// state     | meaning
// RST_PLL   | pll_reset held high for RST_PULSE_CYCLES
// WAIT_LOCK | pll_reset released, waiting for lock_s (timeout -> retry)
// STABLE    | lock seen, must hold for STABLE_CYCLES
// RUN       | system released, watching for loss of lock
// FAIL      | RETRY_MAX consecutive timeouts; waits for retry pulse
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter int unsigned LOCK_WAIT_CYCLES = 27000,
  parameter int unsigned STABLE_CYCLES    = 2700,
  parameter int unsigned RETRY_MAX        = 3,
  parameter int unsigned CNT_W            = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       retry,
  output logic       pll_reset,
  output logic       sys_resetn,
  output logic       locked,
  output logic       fail,
  output logic [7:0] relock_cnt
);

  localparam int unsigned RW = $clog2(RETRY_MAX + 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_LIM   = RW'(RETRY_MAX);

  typedef enum logic [2:0] {
    S_RST_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    retries_q, retries_d, retries_inc;
  logic [7:0]       relock_d;
  logic             sync1_q, lock_s;
  logic             loss;
`ifdef PLL_LOCK_DEGLITCH_EN
  logic [1:0]       low_q, low_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    retries_d   = retries_q;
    retries_inc = retries_q + 1'b1;
    relock_d    = relock_cnt;
    loss        = 1'b0;
`ifdef PLL_LOCK_DEGLITCH_EN
    low_d       = 2'd0;
`endif
    case (state_q)
      S_RST_PLL: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == LOCK_LAST) begin
          retries_d = retries_inc;
          state_d   = (retries_inc == RETRY_LIM) ? S_FAIL : S_RST_PLL;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = S_RUN;
          retries_d = '0;
        end
      end
      S_RUN: begin
`ifdef PLL_LOCK_DEGLITCH_EN
        // Third consecutive low sample is the loss; shorter dips just count up.
        if (!lock_s) begin
          if (low_q == 2'd2) loss = 1'b1;
          else               low_d = low_q + 2'd1;
        end
`else
        loss = !lock_s;
`endif
        if (loss) begin
          state_d  = S_RST_PLL;
          relock_d = (relock_cnt == 8'hff) ? relock_cnt : relock_cnt + 8'd1;
        end
      end
      S_FAIL: begin
        if (retry) begin
          state_d   = S_RST_PLL;
          retries_d = '0;
        end
      end
      default: state_d = S_RST_PLL;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_RST_PLL;
      cnt_q      <= '0;
      retries_q  <= '0;
      sync1_q    <= 1'b0;
      lock_s     <= 1'b0;
      pll_reset  <= 1'b1;
      sys_resetn <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      relock_cnt <= 8'd0;
`ifdef PLL_LOCK_DEGLITCH_EN
      low_q      <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retries_q  <= retries_d;
      sync1_q    <= pll_lock;
      lock_s     <= sync1_q;
      pll_reset  <= (state_d == S_RST_PLL) || (state_d == S_FAIL);
      sys_resetn <= (state_d == S_RUN);
      locked     <= (state_d == S_RUN);
      fail       <= (state_d == S_FAIL);
      relock_cnt <= relock_d;
`ifdef PLL_LOCK_DEGLITCH_EN
      low_q      <= low_d;
`endif
    end
  end

endmodule
